osd_flip_candidate_selector: RTL and testbench
==============================================

Name: osd_flip_candidate_selector

Overview:
- Consumer end of the flip-mask stream in the OSD decoder.
- Accepts a sequence of K-bit flip masks over a valid/ready handshake and computes each candidate's cost: the sum of the latched per-bit reliabilities at the set mask bits.
- Tracks the minimum-cost candidate and, after the last mask, reports the best mask, its cost and its index to the re-encoding stage.

Parameters:
- K, 8, information-set length (mask width); K >= 2
- W, 6, reliability magnitude width per bit
- CW, W+$clog2(K+1), cost width (derived localparam, not overridable)
- IW, $clog2(K*(K-1)/2+1), candidate index/count width (derived localparam)

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; latches reliab and begins a search; ignored unless state is IDLE or DONE
- reliab  input  K*W  packed reliabilities; bit i uses reliab[i*W +: W]
- mask_valid  input  1  flip_mask valid
- mask_ready  output  1  selector can accept a mask
- flip_mask  input  K  candidate flip pattern
- mask_last  input  1  marks the final mask of the search; qualified by mask_valid
- busy  output  1  high in RUN or FLUSH
- result_valid  output  1  one-cycle pulse when the result is final
- best_mask  output  K  minimum-cost mask
- best_cost  output  CW  cost of best_mask
- best_idx  output  IW  0-based acceptance order of best_mask
- cand_count  output  IW  masks accepted in the current search (saturating)

Behaviour:
- Reset values: all outputs 0; best_cost = all-ones; state = IDLE.
- The FSM has four states: IDLE, RUN, FLUSH, DONE.
- IDLE/DONE -> RUN on start:
  - latch reliab into an internal register
  - best_cost <= all-ones; best_mask <= 0; best_idx <= 0; cand_count <= 0
- RUN:
  - mask_ready = 1.
  - A transfer occurs when mask_valid && mask_ready.
  - Stage 1 (transfer cycle): register flip_mask, the current cand_count as tag, and mask_last.
  - cand_count increments on every transfer and saturates at 2^IW-1.
  - Transfer with mask_last = 1 -> FLUSH.
- Stage 2 (one cycle after stage 1): cost = zero-extended sum over i of (mask bit i ? reliab_i : 0), computed into CW bits with no overflow possible.
  - The result and tag are registered.
- Stage 3: if cost < best_cost (strict), update best_mask, best_cost and best_idx.
  - On ties the earlier candidate is kept.
- Latency: a mask accepted at cycle t affects best_* at the end of cycle t+2. Throughput is one mask per cycle.
- FLUSH:
  - mask_ready = 0.
  - Wait until the last-tagged item leaves stage 3.
  - result_valid pulses in the cycle after that update, so best_* are already final; then -> DONE.
- DONE:
  - best_* and cand_count hold their values until the next start.
  - mask_ready = 0.
- Boundary conditions:
  - start during RUN/FLUSH: ignored.
  - mask_valid outside RUN: ignored, no state change.
  - All-zero mask: cost 0, which is a legal candidate.
  - Empty search: not possible; the search ends only on mask_last.
- rst asserted mid-search: immediate return to the reset values; the pipeline valid bits are cleared.
- busy = (state == RUN) || (state == FLUSH).

Optional Feature:
- Macro: OSD_SEL_WEIGHT_CHECK_EN
- Defined:
  - Each accepted mask whose popcount != 2 is excluded from the min-compare, though it still counts in cand_count.
  - An extra output port bad_mask_cnt (IW bits, saturating, reset 0, cleared on start) counts these masks.
- Not defined: no check, no bad_mask_cnt port; every mask competes.

Decomposition:
- Shared package osd_pkg: function popcount; function pair_count(K) = K*(K-1)/2; localparam computation for CW and IW.
- Sub-module osd_mask_cost:
  - pure combinational weighted sum
  - mask + packed reliab -> CW-bit cost
  - instantiated in stage 2 and reusable in other OSD blocks

Test Plan:
- K=8, W=6, reliab = {7,6,5,4,3,2,1,0} (bit7..bit0); stream all 28 two-bit masks in lexicographic order (i<j), last on 28th:
  - best_mask = 8'h03, best_cost = 1, best_idx = 0, cand_count = 28
  - single result_valid pulse
- Same stream with mask_valid toggling every other cycle: identical result; result_valid never earlier than 2 cycles after the last transfer.
- reliab all equal to 5: every cost = 10; best_idx = 0 (tie keeps earliest); best_mask = 8'h03.
- rst asserted for 1 cycle after 10 masks, then new start and a full stream:
  - outputs return to reset values during rst
  - final result matches the fresh-run result
- start pulsed while busy: ignored; reliab not re-latched; result unchanged.
- OSD_SEL_WEIGHT_CHECK_EN defined, stream contains 8'h07 with cost 0 plus the valid pairs:
  - bad_mask_cnt = 1
  - 8'h07 never becomes best_mask

Source files
------------

// File: rtl/osd_pkg.sv
// Shared OSD helpers: selector state encoding, popcount, pair count and the
// derived cost/index widths used by the flip-candidate path.
package osd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } sel_state_t;

  function automatic int pair_count(input int k);
    return k * (k - 1) / 2;
  endfunction

  // Enough headroom for K reliabilities of W bits each to sum without overflow.
  function automatic int cost_width(input int k, input int w);
    return w + $clog2(k + 1);
  endfunction

  function automatic int idx_width(input int k);
    return $clog2(pair_count(k) + 1);
  endfunction

  function automatic int popcount(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/osd_mask_cost.sv
// Combinational weighted sum: adds reliab_i for every set bit i of the mask.
module osd_mask_cost #(
  parameter int K  = 8,
  parameter int W  = 6,
  parameter int CW = 10
) (
  input  logic [K-1:0]   mask,
  input  logic [K*W-1:0] reliab,
  output logic [CW-1:0]  cost
);

  always_comb begin
    cost = '0;
    for (int i = 0; i < K; i++) begin
      if (mask[i]) cost = cost + CW'(reliab[i*W +: W]);
    end
  end

endmodule

// File: rtl/osd_flip_candidate_selector.sv
// Flip-mask consumer: three-stage cost pipeline with minimum tracking.
// Optional OSD_SEL_WEIGHT_CHECK_EN drops non-weight-2 masks and counts them.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   RUN   | accepting masks
//   FLUSH | last mask taken, draining stages 2/3
//   DONE  | result held until next start
module osd_flip_candidate_selector
  import osd_pkg::*;
#(
  parameter  int K  = 8,
  parameter  int W  = 6,
  localparam int CW = cost_width(K, W),
  localparam int IW = idx_width(K)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [K*W-1:0] reliab,
  input  logic           mask_valid,
  output logic           mask_ready,
  input  logic [K-1:0]   flip_mask,
  input  logic           mask_last,
  output logic           busy,
  output logic           result_valid,
  output logic [K-1:0]   best_mask,
  output logic [CW-1:0]  best_cost,
  output logic [IW-1:0]  best_idx,
  output logic [IW-1:0]  cand_count
`ifdef OSD_SEL_WEIGHT_CHECK_EN
  ,
  output logic [IW-1:0]  bad_mask_cnt
`endif
);

  sel_state_t     state;
  logic [K*W-1:0] rel_q;
  logic           xfer;

  logic           s1_valid, s1_last, s1_ok;
  logic [K-1:0]   s1_mask;
  logic [IW-1:0]  s1_tag;

  logic           s2_valid, s2_last, s2_ok;
  logic [K-1:0]   s2_mask;
  logic [IW-1:0]  s2_tag;
  logic [CW-1:0]  s2_cost;
  logic [CW-1:0]  cost;

  assign mask_ready = (state == ST_RUN);
  assign busy       = (state == ST_RUN) || (state == ST_FLUSH);
  assign xfer       = mask_valid && mask_ready;

`ifdef OSD_SEL_WEIGHT_CHECK_EN
  assign s1_ok = (popcount(64'(s1_mask)) == 2);
`else
  assign s1_ok = 1'b1;
`endif

  osd_mask_cost #(.K(K), .W(W), .CW(CW)) u_cost (
    .mask   (s1_mask),
    .reliab (rel_q),
    .cost   (cost)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      rel_q        <= '0;
      s1_valid     <= 1'b0;
      s1_last      <= 1'b0;
      s1_mask      <= '0;
      s1_tag       <= '0;
      s2_valid     <= 1'b0;
      s2_last      <= 1'b0;
      s2_ok        <= 1'b0;
      s2_mask      <= '0;
      s2_tag       <= '0;
      s2_cost      <= '0;
      result_valid <= 1'b0;
      best_mask    <= '0;
      best_cost    <= '1;
      best_idx     <= '0;
      cand_count   <= '0;
`ifdef OSD_SEL_WEIGHT_CHECK_EN
      bad_mask_cnt <= '0;
`endif
    end else begin
      result_valid <= 1'b0;
      s1_valid     <= xfer;
      s2_valid     <= s1_valid;
      s2_last      <= s1_last;
      s2_ok        <= s1_ok;
      s2_mask      <= s1_mask;
      s2_tag       <= s1_tag;
      s2_cost      <= cost;

      if (xfer) begin
        s1_mask <= flip_mask;
        s1_tag  <= cand_count;
        s1_last <= mask_last;
        if (cand_count != '1) cand_count <= cand_count + IW'(1);
`ifdef OSD_SEL_WEIGHT_CHECK_EN
        if (popcount(64'(flip_mask)) != 2 && bad_mask_cnt != '1)
          bad_mask_cnt <= bad_mask_cnt + IW'(1);
`endif
      end

      // Strict compare keeps the earliest candidate on ties.
      if (s2_valid && s2_ok && (s2_cost < best_cost)) begin
        best_mask <= s2_mask;
        best_cost <= s2_cost;
        best_idx  <= s2_tag;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            rel_q      <= reliab;
            best_mask  <= '0;
            best_cost  <= '1;
            best_idx   <= '0;
            cand_count <= '0;
`ifdef OSD_SEL_WEIGHT_CHECK_EN
            bad_mask_cnt <= '0;
`endif
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (xfer && mask_last) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          // Last item is in stage 3 this cycle; best_* settle at this edge.
          if (s2_valid && s2_last) begin
            result_valid <= 1'b1;
            state        <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_osd_flip_candidate_selector.sv
// Directed bench for osd_flip_candidate_selector with an array-based cost model.
module tb_osd_flip_candidate_selector;
  import osd_pkg::*;

  localparam int K  = 8;
  localparam int W  = 6;
  localparam int CW = cost_width(K, W);
  localparam int IW = idx_width(K);

  logic           clk = 1'b0;
  logic           rst, start, mask_valid, mask_last;
  logic [K*W-1:0] reliab;
  logic [K-1:0]   flip_mask;
  logic           mask_ready, busy, result_valid;
  logic [K-1:0]   best_mask;
  logic [CW-1:0]  best_cost;
  logic [IW-1:0]  best_idx, cand_count;
`ifdef OSD_SEL_WEIGHT_CHECK_EN
  logic [IW-1:0]  bad_mask_cnt;
`endif

  osd_flip_candidate_selector #(.K(K), .W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .reliab       (reliab),
    .mask_valid   (mask_valid),
    .mask_ready   (mask_ready),
    .flip_mask    (flip_mask),
    .mask_last    (mask_last),
    .busy         (busy),
    .result_valid (result_valid),
    .best_mask    (best_mask),
    .best_cost    (best_cost),
    .best_idx     (best_idx),
    .cand_count   (cand_count)
`ifdef OSD_SEL_WEIGHT_CHECK_EN
    ,
    .bad_mask_cnt (bad_mask_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_xfer = 0;
  int exp_cnt = 0;
  int res_pulses = 0;
  bit in_search = 1'b0;

  int           rel[K];
  logic [K-1:0] mq[$];
  logic [K-1:0] exp_mask;
  int           exp_cost, exp_idx;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic logic [K*W-1:0] pack_rel();
    logic [K*W-1:0] v;
    v = '0;
    for (int i = 0; i < K; i++) v[i*W +: W] = W'(rel[i]);
    return v;
  endfunction

  // Cheapest eligible mask in arrival order; first one wins ties.
  task automatic compute_expected();
    exp_mask = '0;
    exp_cost = (1 << CW) - 1;
    exp_idx  = 0;
    for (int n = 0; n < mq.size(); n++) begin
      int c;
      int pc;
      c  = 0;
      pc = 0;
      for (int i = 0; i < K; i++) begin
        if (mq[n][i]) begin
          c  += rel[i];
          pc++;
        end
      end
`ifdef OSD_SEL_WEIGHT_CHECK_EN
      if (pc != 2) continue;
`endif
      if (c < exp_cost) begin
        exp_cost = c;
        exp_mask = mq[n];
        exp_idx  = n;
      end
    end
  endtask

  task automatic build_pairs();
    mq.delete();
    for (int i = 0; i < K - 1; i++)
      for (int j = i + 1; j < K; j++) begin
        logic [K-1:0] m;
        m = '0;
        m[i] = 1'b1;
        m[j] = 1'b1;
        mq.push_back(m);
      end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("rst_result_valid", result_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", mask_ready, 0);
      check("rst_best_mask", best_mask, 0);
      check("rst_best_cost", best_cost, (1 << CW) - 1);
      check("rst_best_idx", best_idx, 0);
      check("rst_cand_count", cand_count, 0);
`ifdef OSD_SEL_WEIGHT_CHECK_EN
      check("rst_bad_cnt", bad_mask_cnt, 0);
`endif
    end else begin
      if (result_valid) begin
        in_search = 1'b0;
        res_pulses++;
        check("res_mask", best_mask, exp_mask);
        check("res_cost", best_cost, exp_cost);
        check("res_idx", best_idx, exp_idx);
        check("res_latency", cyc, last_xfer + 3);
      end
      check("busy", busy, in_search);
      if (!in_search) check("ready_idle", mask_ready, 0);
      check("cand_count", cand_count, exp_cnt);
    end
  end

  task automatic do_start(input logic [K*W-1:0] rv, input bit accept);
    reliab = rv;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    if (accept) begin
      exp_cnt    = 0;
      res_pulses = 0;
      in_search  = 1'b1;
    end
  endtask

  task automatic send(input logic [K-1:0] m, input bit last, input int gap);
    mask_valid = 1'b1;
    flip_mask  = m;
    mask_last  = last;
    @(negedge clk);
    check("ready_run", mask_ready, 1);
    @(posedge clk); #1;
    exp_cnt++;
    last_xfer  = cyc - 1;
    mask_valid = 1'b0;
    mask_last  = 1'b0;
    if (last) begin
      @(negedge clk);
      check("ready_flush", mask_ready, 0);
      @(posedge clk); #1;
    end
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_range(input int lo, input int hi, input int gap);
    for (int i = lo; i <= hi; i++) send(mq[i], i == mq.size() - 1, gap);
  endtask

  task automatic wait_result();
    int t;
    t = 0;
    while (res_pulses == 0 && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    check("result_seen", res_pulses > 0, 1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("result_pulses", res_pulses, 1);
    check("hold_mask", best_mask, exp_mask);
    check("hold_cost", best_cost, exp_cost);
    check("hold_idx", best_idx, exp_idx);
  endtask

  task automatic check_t1_literals(input string tag);
    check({tag, "_mask"}, best_mask, 8'h03);
    check({tag, "_cost"}, best_cost, 1);
    check({tag, "_idx"}, best_idx, 0);
    check({tag, "_cnt"}, cand_count, 28);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; mask_valid = 1'b0; mask_last = 1'b0;
    flip_mask = '0; reliab = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Ascending reliabilities, back-to-back pairs.
    for (int i = 0; i < K; i++) rel[i] = i;
    build_pairs();
    compute_expected();
    check("model_t1_mask", exp_mask, 8'h03);
    check("model_t1_cost", exp_cost, 1);
    do_start(pack_rel(), 1);
    send_range(0, mq.size() - 1, 0);
    wait_result();
    check_t1_literals("t1");

    // Same stream with valid every other cycle.
    do_start(pack_rel(), 1);
    send_range(0, mq.size() - 1, 1);
    wait_result();
    check_t1_literals("t2");

    // All-equal reliabilities: ties keep the first pair.
    for (int i = 0; i < K; i++) rel[i] = 5;
    compute_expected();
    check("model_t3_cost", exp_cost, 10);
    do_start(pack_rel(), 1);
    send_range(0, mq.size() - 1, 0);
    wait_result();
    check("t3_mask", best_mask, 8'h03);
    check("t3_cost", best_cost, 10);
    check("t3_idx", best_idx, 0);

    // Masks offered in DONE must be dropped.
    mask_valid = 1'b1; flip_mask = 8'h01; mask_last = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    mask_valid = 1'b0; mask_last = 1'b0;
    check("done_ignore_cnt", cand_count, 28);
    check("done_ignore_mask", best_mask, 8'h03);

    // Reset after 10 masks, then a fresh full search.
    for (int i = 0; i < K; i++) rel[i] = i;
    compute_expected();
    do_start(pack_rel(), 1);
    send_range(0, 9, 0);
    rst = 1'b1;
    in_search = 1'b0;
    exp_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_start(pack_rel(), 1);
    send_range(0, mq.size() - 1, 0);
    wait_result();
    check_t1_literals("t4");

    // Start while busy carries different reliabilities and must be ignored.
    do_start(pack_rel(), 1);
    send_range(0, 4, 0);
    do_start({(K*W){1'b0}}, 0);
    send_range(5, mq.size() - 1, 0);
    wait_result();
    check_t1_literals("t5");

`ifdef OSD_SEL_WEIGHT_CHECK_EN
    // Weight-3 mask of cost 0 ahead of the pairs must not win.
    for (int i = 0; i < K; i++) rel[i] = (i < 3) ? 0 : 5;
    build_pairs();
    mq.push_front(8'h07);
    compute_expected();
    check("model_t6_mask", exp_mask, 8'h03);
    do_start(pack_rel(), 1);
    send_range(0, mq.size() - 1, 0);
    wait_result();
    check("t6_mask", best_mask, 8'h03);
    check("t6_cost", best_cost, 0);
    check("t6_idx", best_idx, 1);
    check("t6_cnt", cand_count, 29);
    check("t6_bad_cnt", bad_mask_cnt, 1);
`else
    // All-zero mask is a legal zero-cost candidate.
    for (int i = 0; i < K; i++) rel[i] = i;
    mq.delete();
    mq.push_back(8'h11);
    mq.push_back(8'h30);
    mq.push_back(8'h00);
    mq.push_back(8'h03);
    compute_expected();
    check("model_t6_idx", exp_idx, 2);
    do_start(pack_rel(), 1);
    send_range(0, mq.size() - 1, 0);
    wait_result();
    check("t6_mask", best_mask, 8'h00);
    check("t6_cost", best_cost, 0);
    check("t6_idx", best_idx, 2);
    check("t6_cnt", cand_count, 4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
